// File: rtl/fp_norm_pkg.sv
// Shared widths, helper functions and payload types for the FP normaliser.
package fp_norm_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned SIG_W_DEF = 27;
  localparam int unsigned TAG_W_DEF = 4;

  // Width of the leading-zero count for a given significand width.
  function automatic int unsigned lz_width(input int unsigned sig_w);
    return $clog2(sig_w);
  endfunction

  // All-ones exponent (infinity / NaN encoding) for a given exponent width.
  function automatic int unsigned exp_max(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  localparam int unsigned LZ_W    = lz_width(SIG_W_DEF);
  localparam int unsigned EXP_MAX = exp_max(EXP_W_DEF);

  // Stage-1 payload: captured inputs plus the leading-zero count.
  typedef struct packed {
    logic [SIG_W_DEF-1:0] sig;
    logic                 carry;
    logic [EXP_W_DEF-1:0] exp;
    logic [LZ_W-1:0]      lz;
    logic [TAG_W_DEF-1:0] tag;
  } norm_s1_t;

  // Stage-2 payload: normalised result presented downstream.
  typedef struct packed {
    logic [SIG_W_DEF-1:0] sig;
    logic [EXP_W_DEF-1:0] exp;
    logic [TAG_W_DEF-1:0] tag;
    logic                 zero;
    logic                 denorm;
    logic                 ovf;
  } norm_res_t;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; returns SIG_W for an all-zero input.
module fp_lzc #(
  parameter int unsigned SIG_W = 27,
  parameter int unsigned LZ_W  = 5
) (
  input  logic [SIG_W-1:0] sig_i,
  output logic [LZ_W-1:0]  lz_c
);

  // Scan upward so the highest set bit determines the final count.
  always_comb begin
    lz_c = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (sig_i[i]) lz_c = LZ_W'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage normaliser between the significand ALU and the rounding stage.
module fp_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned SIG_W = SIG_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_sig,
  input  logic             in_carry,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_sig,
  output logic [EXP_W-1:0] out_exp,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_denorm,
  output logic             out_ovf
);

  localparam int unsigned LZW  = lz_width(SIG_W);
  localparam int unsigned EMAX = exp_max(EXP_W);
  localparam int unsigned XW   = EXP_W + 1;

  typedef struct packed {
    logic [SIG_W-1:0] sig;
    logic             carry;
    logic [EXP_W-1:0] exp;
    logic [LZW-1:0]   lz;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [SIG_W-1:0] sig;
    logic [EXP_W-1:0] exp;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             denorm;
    logic             ovf;
  } res_t;

  logic           s1_valid_q, s2_valid_q;
  s1_t            s1_q, s1_d;
  res_t           s2_q, res_d;
  logic [LZW-1:0] lz_c;
  logic           s2_load_c;
  logic [XW-1:0]  exp_x_c, exp_p1_c, lz_x_c;

  fp_lzc #(
    .SIG_W (SIG_W),
    .LZ_W  (LZW)
  ) u_lzc (
    .sig_i (in_sig),
    .lz_c  (lz_c)
  );

  assign s2_load_c = !s2_valid_q || out_ready;
  assign in_ready  = !flush && (!s1_valid_q || s2_load_c);

  assign s1_d = '{sig: in_sig, carry: in_carry, exp: in_exp, lz: lz_c, tag: in_tag};

  // Stage 1: capture the beat with its leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Widened exponent arithmetic so compare/subtract never wraps.
  assign exp_x_c  = XW'(s1_q.exp);
  assign exp_p1_c = exp_x_c + XW'(1);
  assign lz_x_c   = XW'(s1_q.lz);

  // Mode selection: carry, zero, exponent-zero, full shift, gradual underflow.
  always_comb begin
    res_d     = '0;
    res_d.tag = s1_q.tag;
    if (s1_q.carry) begin
      if (exp_p1_c >= XW'(EMAX)) begin
        res_d.ovf = 1'b1;
        res_d.exp = EXP_W'(EMAX);
      end else begin
        res_d.sig = {1'b1, s1_q.sig[SIG_W-1:2], s1_q.sig[1] | s1_q.sig[0]};
        res_d.exp = exp_p1_c[EXP_W-1:0];
      end
    end else if (s1_q.sig == '0) begin
      res_d.zero = 1'b1;
    end else if (s1_q.exp == '0) begin
      res_d.sig = s1_q.sig;
      if (s1_q.sig[SIG_W-1]) res_d.exp = EXP_W'(1);
      else                   res_d.denorm = 1'b1;
    end else if (lz_x_c < exp_x_c) begin
      res_d.sig = s1_q.sig << s1_q.lz;
      res_d.exp = EXP_W'(exp_x_c - lz_x_c);
    end else begin
      res_d.sig    = s1_q.sig << (s1_q.exp - EXP_W'(1));
      res_d.denorm = 1'b1;
    end
  end

  // Stage 2: hold the result stable until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_load_c) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_q <= res_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_sig    = s2_q.sig;
  assign out_exp    = s2_q.exp;
  assign out_tag    = s2_q.tag;
  assign out_zero   = s2_q.zero;
  assign out_denorm = s2_q.denorm;
  assign out_ovf    = s2_q.ovf;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Randomised and directed bench for fp_norm_pipe against an arithmetic model.
module tb_fp_norm_pipe;
  import fp_norm_pkg::*;

  localparam int unsigned SIG_W = 27;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned TAG_W = 4;

  logic             clk, rst_n, flush;
  logic             in_valid, in_ready, in_carry;
  logic [SIG_W-1:0] in_sig;
  logic [EXP_W-1:0] in_exp;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [SIG_W-1:0] out_sig;
  logic [EXP_W-1:0] out_exp;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero, out_denorm, out_ovf;

  norm_res_t        exp_q[$];
  logic [TAG_W-1:0] tag_log[$];
  norm_res_t        last_out, snap;
  logic             stall_prev;
  int               n_cmp, n_err;

  fp_norm_pipe #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sig     (in_sig),
    .in_carry   (in_carry),
    .in_exp     (in_exp),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sig    (out_sig),
    .out_exp    (out_exp),
    .out_tag    (out_tag),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: normalise by repeated doubling and plain integer arithmetic.
  function automatic norm_res_t ref_norm(input logic [SIG_W-1:0] sig, input logic carry,
                                         input int unsigned e, input logic [TAG_W-1:0] tag);
    norm_res_t       r;
    longint unsigned s, t, top, full;
    int unsigned     lz, emax;
    emax = (32'd1 << EXP_W) - 32'd1;
    top  = 64'd1 << (SIG_W - 1);
    full = top * 2;
    s    = 64'(sig);
    r    = '0;
    r.tag = tag;
    t  = s;
    lz = 0;
    while (t != 0 && t < top) begin
      t  = t * 2;
      lz = lz + 1;
    end
    if (carry) begin
      if (e + 1 >= emax) begin
        r.ovf = 1'b1;
        r.exp = EXP_W'(emax);
      end else begin
        r.sig = SIG_W'(top | (s / 2) | (s % 2));
        r.exp = EXP_W'(e + 1);
      end
    end else if (s == 0) begin
      r.zero = 1'b1;
    end else if (e == 0) begin
      r.sig = sig;
      if (s >= top) r.exp = EXP_W'(1);
      else          r.denorm = 1'b1;
    end else if (lz < e) begin
      r.sig = SIG_W'(s * (64'd1 << lz));
      r.exp = EXP_W'(e - lz);
    end else begin
      r.sig    = SIG_W'((s * (64'd1 << (e - 1))) % full);
      r.denorm = 1'b1;
    end
    return r;
  endfunction

  // One clock: check outputs and update the model before the edge, then advance.
  task automatic cycle(output logic acc);
    logic      take;
    norm_res_t cur;
    @(negedge clk);
    acc  = in_valid && in_ready;
    take = out_valid && out_ready;
    cur  = {out_sig, out_exp, out_tag, out_zero, out_denorm, out_ovf};
    if (stall_prev) begin
      check_eq("stall_valid", 64'(out_valid), 64'(1));
      check_eq("stall_stable", 64'(cur), 64'(snap));
    end
    if (out_valid && exp_q.size() == 0) check_eq("unexpected_valid", 64'(out_valid), 64'(0));
    if (take && exp_q.size() != 0) begin
      check_eq("result", 64'(cur), 64'(exp_q.pop_front()));
      last_out = cur;
      tag_log.push_back(out_tag);
    end
    stall_prev = out_valid && !out_ready && !flush;
    snap       = cur;
    if (flush) exp_q.delete();
    if (acc) exp_q.push_back(ref_norm(in_sig, in_carry, 32'(in_exp), in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [SIG_W-1:0] sig, input logic carry,
                       input logic [EXP_W-1:0] e, input logic [TAG_W-1:0] tag);
    in_sig   = sig;
    in_carry = carry;
    in_exp   = e;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [SIG_W-1:0] sig, input logic carry,
                      input logic [EXP_W-1:0] e, input logic [TAG_W-1:0] tag);
    logic acc;
    acc = 1'b0;
    drive(sig, carry, e, tag);
    for (int k = 0; k < 40 && !acc; k++) cycle(acc);
    if (!acc) check_eq("send_timeout", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && (exp_q.size() != 0 || out_valid); k++) cycle(acc);
    check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic             acc;
    int               t;
    logic [SIG_W-1:0] rs;
    logic [EXP_W-1:0] re;
    n_cmp = 0; n_err = 0; stall_prev = 1'b0; last_out = '0; snap = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sig = '0; in_carry = 1'b0; in_exp = '0; in_tag = '0;

    #1;
    check_eq("reset_valid", 64'(out_valid), 64'(0));
    check_eq("reset_outs", 64'({out_sig, out_exp, out_tag, out_zero, out_denorm, out_ovf}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry case with latency from an empty pipe.
    drive(27'h0000003, 1'b1, 8'd10, 4'h1);
    cycle(acc);
    check_eq("lat_accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
    check_eq("lat_edge1", 64'(out_valid), 64'(0));
    cycle(acc);
    check_eq("lat_edge2", 64'(out_valid), 64'(1));
    drain();
    check_eq("carry_sig", 64'(last_out.sig), 64'h4000001);
    check_eq("carry_exp", 64'(last_out.exp), 64'd11);
    check_eq("carry_flags", 64'({last_out.zero, last_out.denorm, last_out.ovf}), 64'(0));

    send(27'h0100000, 1'b0, 8'd100, 4'h2); drain();
    check_eq("shift_sig", 64'(last_out.sig), 64'h4000000);
    check_eq("shift_exp", 64'(last_out.exp), 64'd94);
    send(27'h0100000, 1'b0, 8'd4, 4'h3); drain();
    check_eq("uflow_sig", 64'(last_out.sig), 64'h0800000);
    check_eq("uflow_exp", 64'(last_out.exp), 64'd0);
    check_eq("uflow_denorm", 64'(last_out.denorm), 64'd1);
    send(27'h0000003, 1'b1, 8'd254, 4'h4); drain();
    check_eq("ovf_exp", 64'(last_out.exp), 64'd255);
    check_eq("ovf_sig", 64'(last_out.sig), 64'd0);
    check_eq("ovf_flag", 64'(last_out.ovf), 64'd1);
    send(27'h0000000, 1'b0, 8'd1, 4'h5); drain();
    check_eq("zero_exp", 64'(last_out.exp), 64'd0);
    check_eq("zero_flag", 64'(last_out.zero), 64'd1);
    send(27'h4000005, 1'b0, 8'd0, 4'h6); drain();
    check_eq("promote_exp", 64'(last_out.exp), 64'd1);
    check_eq("promote_sig", 64'(last_out.sig), 64'h4000005);
    send(27'h0000100, 1'b0, 8'd0, 4'h7); drain();
    check_eq("sub_sig", 64'(last_out.sig), 64'h0000100);
    check_eq("sub_denorm", 64'({last_out.exp, last_out.denorm}), 64'd1);

    // Backpressure: two beats fill the pipe, then stall, then release.
    tag_log.delete();
    out_ready = 1'b0;
    t = 1;
    for (int c = 0; c < 5; c++) begin
      drive(27'h0100000 + SIG_W'(t), 1'b0, 8'd50, TAG_W'(t));
      cycle(acc);
      if (acc) t++;
    end
    check_eq("bp_accepts", 64'(t - 1), 64'd2);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && t <= 6; c++) begin
      drive(27'h0100000 + SIG_W'(t), 1'b0, 8'd50, TAG_W'(t));
      cycle(acc);
      if (acc) t++;
    end
    drain();
    check_eq("bp_count", 64'(tag_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < tag_log.size(); i++)
      check_eq("bp_order", 64'(tag_log[i]), 64'(i + 1));

    // Flush with two beats in flight and a competing input.
    out_ready = 1'b0;
    send(27'h0001234, 1'b0, 8'd30, 4'h8);
    send(27'h0005678, 1'b0, 8'd30, 4'h9);
    drive(27'h0000abc, 1'b0, 8'd30, 4'ha);
    flush = 1'b1;
    #1;
    check_eq("flush_in_ready", 64'(in_ready), 64'd0);
    cycle(acc);
    check_eq("flush_no_accept", 64'(acc), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (3) cycle(acc);

    // Asynchronous reset between clock edges.
    out_ready = 1'b0;
    send(27'h0000f00, 1'b0, 8'd40, 4'hb);
    send(27'h0000e00, 1'b0, 8'd40, 4'hc);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_outs", 64'({out_sig, out_exp, out_tag, out_zero, out_denorm, out_ovf}), 64'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Randomised traffic with random backpressure and rare flushes.
    for (int c = 0; c < 600; c++) begin
      rs = ($urandom_range(0, 19) == 0) ? '0 : SIG_W'($urandom) >> $urandom_range(0, 26);
      re = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom_range(0, 8)) : EXP_W'($urandom_range(0, 255));
      drive(rs, ($urandom_range(0, 9) == 0) && (re != 8'd255), re, TAG_W'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      cycle(acc);
    end
    flush = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Parametrised, two-stage pipelined normaliser for the FP add/sub datapath. Sits between the significand ALU and the rounding stage.
- Takes the raw summed significand, the ALU carry-out and the pre-normalisation exponent. Returns the normalised significand plus the final exponent, not a shift delta.
- Adds over the single-cycle version: gradual-underflow clamping for any exponent, subnormal-to-normal promotion, overflow-to-infinity, sticky preservation, valid/ready flow control and flush.

Parameters:
- EXP_W, 8, exponent field width.
- SIG_W, 27, significand width including hidden, guard, round and sticky bits; MSB is the hidden-bit position.
- TAG_W, 4, width of an opaque sideband tag passed through unchanged.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_sig  in  SIG_W  summed significand.
- in_carry  in  1  ALU carry-out.
- in_exp  in  EXP_W  pre-normalisation biased exponent.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sig  out  SIG_W  normalised significand.
- out_exp  out  EXP_W  final biased exponent.
- out_tag  out  TAG_W  tag travelling with the result.
- out_zero  out  1  result is zero.
- out_denorm  out  1  result is subnormal.
- out_ovf  out  1  exponent overflowed; result is infinity.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids clear; out_valid=0; every data and flag output = 0. Reset mid-operation discards in-flight beats with no partial output.
- Pipeline:
  - S1 registers the inputs together with the leading-zero count lz.
  - S2 registers the shifted significand, exponent and flags.
  - Latency is exactly 2 cycles from the accepting edge when out_ready=1.
- Handshake:
  - A transfer occurs when valid and ready are both high on a clock edge.
  - S2 can load when S2 is empty or out_ready=1.
  - in_ready = !flush && (!S1_valid || S2 can load).
  - Full throughput is 1 beat/cycle.
  - Once out_valid is asserted, out_* stays stable until the beat is taken.
  - Beats leave in order, none are lost, and at most 2 are held.
- Flush: clears both valids on the next edge. in_ready=0 while flush=1, so flush wins over a simultaneous in_valid.
- Mode priority, evaluated in S2 on the S1 values. Let MAX = 2^EXP_W-1 and M = SIG_W-1.
  1. carry=1:
     - sig_out = {1, sig[M:1]}, with bit0 = sig[1] | sig[0] (sticky kept); exp+1.
     - If exp+1 == MAX: out_ovf=1, out_exp=MAX, out_sig=0.
  2. sig==0: out_sig=0, out_exp=0, out_zero=1, whatever the exponent.
  3. exp==0:
     - If sig[M]=1: out_exp=1, no shift (promotion from subnormal to normal).
     - Otherwise: no shift, out_exp=0, out_denorm=1.
  4. lz < exp: out_sig = sig << lz; out_exp = exp - lz.
  5. lz >= exp: out_sig = sig << (exp-1); out_exp=0; out_denorm=1.
- Width rules:
  - Left shifts fill with zeros.
  - lz width is $clog2(SIG_W).
  - The exponent compare and subtract use EXP_W+1 bits, so there is no wrap-around.
  - exp==MAX on input with carry=0 is passed through unchanged; NaN/Inf are handled upstream.
- Flags are mutually exclusive; all are 0 in modes 4 and normal-3.

Decomposition:
- Package fp_norm_pkg holds:
  - localparam helpers for LZ_W and EXP_MAX;
  - typedef struct norm_s1_t {sig, carry, exp, lz, tag};
  - typedef struct norm_res_t {sig, exp, tag, zero, denorm, ovf}.
- Sub-module fp_lzc, a parametrised leading-zero counter (width SIG_W, output LZ_W; lz=SIG_W when the input is zero). It is instantiated in S1.

Test Plan (defaults SIG_W=27, EXP_W=8):
- Carry case: carry=1, sig=27'h0000003, exp=10 -> out_sig=27'h4000001, out_exp=11, all flags 0, out_valid exactly 2 cycles after acceptance.
- Normal left shift: sig=27'h0100000, exp=100 -> out_sig=27'h4000000, out_exp=94. Then sig=27'h0100000, exp=4 -> out_sig=27'h0800000, out_exp=0, out_denorm=1.
- Overflow and zero: carry=1, exp=254 -> out_exp=255, out_sig=0, out_ovf=1. Then sig=0, exp=1 -> out_exp=0, out_zero=1.
- Exponent-zero cases: exp=0, sig=27'h4000005 -> out_exp=1, sig unchanged. Then exp=0, sig=27'h0000100 -> unchanged, out_denorm=1.
- Backpressure and ordering: stream tags 1..6 back-to-back with out_ready held low for 5 cycles -> in_ready drops after 2 accepts, out_* stable while stalled, tags emerge 1..6 in order with none lost; then full rate with out_ready=1.
- Flush and async reset: flush with 2 beats in flight plus in_valid high -> no output for those beats, in_ready=0 during flush. Pulsing rst_n low mid-stream with no clock edge -> out_valid and all outputs are 0 immediately.
